// File: rtl/tensor_bank_sequencer_if.sv
// Bus bundle for tensor_bank_sequencer: read-stream control, result writes and the tensor RAM bank port.
// The sequencer takes the slave modport; the layer controller / RAM wrapper side takes master.
interface tensor_bank_sequencer_if #(
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int D_WIDTH   = 128,
    parameter int NUM_BANKS = 2
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int DIM_W  = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                           start;
    logic [ADDR_W:0]                rd_count;
    logic [DIM_W-1:0]               out_w;
    logic [DIM_W-1:0]               out_h;
    logic                           swap;
    logic                           rd_ready;
    logic                           rd_valid;
    logic [D_WIDTH-1:0]             rd_data;
    logic                           rd_last;
    logic                           rd_done;
    logic                           busy;
    logic [BANK_W-1:0]              rd_bank;
    logic                           wr_valid;
    logic [DIM_W-1:0]               wr_row;
    logic [DIM_W-1:0]               wr_col;
    logic [D_WIDTH-1:0]             wr_data;
    logic                           wr_err;
    logic [ADDR_W-1:0]              ram_addr_r;
    logic [NUM_BANKS*D_WIDTH-1:0]   ram_dout;
    logic [NUM_BANKS-1:0]           ram_we;
    logic [ADDR_W-1:0]              ram_addr_w;
    logic [D_WIDTH-1:0]             ram_din;

    modport master (
        output start, rd_count, out_w, out_h, swap, rd_ready,
               wr_valid, wr_row, wr_col, wr_data, ram_dout,
        input  rd_valid, rd_data, rd_last, rd_done, busy, rd_bank,
               wr_err, ram_addr_r, ram_we, ram_addr_w, ram_din
    );

    modport slave (
        input  start, rd_count, out_w, out_h, swap, rd_ready,
               wr_valid, wr_row, wr_col, wr_data, ram_dout,
        output rd_valid, rd_data, rd_last, rd_done, busy, rd_bank,
               wr_err, ram_addr_r, ram_we, ram_addr_w, ram_din
    );
endinterface

// File: rtl/tensor_bank_sequencer.sv
// Rotating N-bank activation store: streams the read bank to the sliding window while
// STA/max-pool results land in the next bank; rotation advances on layer-boundary swaps.
module tensor_bank_sequencer #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int D_WIDTH    = 128,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LATENCY = 1
) (
    input logic                    clk,
    input logic                    reset,
    tensor_bank_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int DIM_W  = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state, state_d;
    logic [ADDR_W:0]     issue_cnt;
    logic [ADDR_W:0]     rd_count_q;
    logic [DIM_W-1:0]    out_w_q;
    logic [DIM_W-1:0]    out_h_q;
    logic [BANK_W-1:0]   rd_bank_q;
    logic [BANK_W-1:0]   bank_next;
    logic                swap_pending;
    logic                done_q;

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [RD_LATENCY-1:0] last_pipe;
    logic [BANK_W-1:0]     bank_pipe [RD_LATENCY];

    logic                issue;
    logic                issue_last;
    logic                done_d;
    logic                rd_valid_w;
    logic                rd_last_w;
    logic [D_WIDTH-1:0]  rd_data_w;

    logic [NUM_BANKS-1:0] we_onehot;
    logic                 wr_in_range;
    logic [ADDR_W-1:0]    wr_addr;
    logic [NUM_BANKS-1:0] ram_we_q;
    logic [ADDR_W-1:0]    ram_addr_w_q;
    logic [D_WIDTH-1:0]   ram_din_q;
    logic                 wr_err_q;

    // Successor of the read bank doubles as the write bank, so the two can never collide.
    assign bank_next  = (rd_bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_bank_q + 1'b1;
    assign issue_last = (issue_cnt == rd_count_q - 1'b1);
    assign rd_valid_w = vld_pipe[RD_LATENCY-1];
    assign rd_last_w  = rd_valid_w & last_pipe[RD_LATENCY-1];

    assign we_onehot   = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_next;
    assign wr_in_range = (bus.wr_row < out_h_q) && (bus.wr_col < out_w_q);
    assign wr_addr     = ADDR_W'(bus.wr_row) * ADDR_W'(out_w_q) + ADDR_W'(bus.wr_col);

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.rd_count != '0) state_d = READ;
                    else                    done_d  = 1'b1;
                end
            end
            READ: begin
                if (bus.rd_ready) begin
                    issue = 1'b1;
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_last_w) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            issue_cnt    <= '0;
            rd_count_q   <= '0;
            out_w_q      <= '0;
            out_h_q      <= '0;
            rd_bank_q    <= '0;
            swap_pending <= 1'b0;
            done_q       <= 1'b0;
            vld_pipe     <= '0;
            last_pipe    <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) bank_pipe[i] <= '0;
            ram_we_q     <= '0;
            ram_addr_w_q <= '0;
            ram_din_q    <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= done_d;

            if (state == IDLE && bus.start) begin
                rd_count_q <= bus.rd_count;
                out_w_q    <= bus.out_w;
                out_h_q    <= bus.out_h;
                issue_cnt  <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end

            vld_pipe[0]  <= issue;
            last_pipe[0] <= issue & issue_last;
            bank_pipe[0] <= rd_bank_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
            end

            // Swaps seen while busy fold into one rotation applied on the edge back into IDLE.
            if (state == IDLE) begin
                if (bus.swap) rd_bank_q <= bank_next;
            end else if (state_d == IDLE) begin
                if (swap_pending || bus.swap) rd_bank_q <= bank_next;
                swap_pending <= 1'b0;
            end else if (bus.swap) begin
                swap_pending <= 1'b1;
            end

            ram_we_q <= '0;
            wr_err_q <= 1'b0;
            if (bus.wr_valid) begin
                ram_addr_w_q <= wr_addr;
                ram_din_q    <= bus.wr_data;
                if (wr_in_range) ram_we_q <= we_onehot;
                else             wr_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_w = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (rd_valid_w && bank_pipe[RD_LATENCY-1] == BANK_W'(k))
                rd_data_w = bus.ram_dout[k*D_WIDTH +: D_WIDTH];
        end
    end

    assign bus.rd_valid   = rd_valid_w;
    assign bus.rd_data    = rd_data_w;
    assign bus.rd_last    = rd_last_w;
    assign bus.rd_done    = done_q;
    assign bus.busy       = (state != IDLE);
    assign bus.rd_bank    = rd_bank_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.ram_addr_r = issue_cnt[ADDR_W-1:0];
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr_w = ram_addr_w_q;
    assign bus.ram_din    = ram_din_q;
endmodule
